hack_rom_loader: RTL and testbench

HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

---
 rtl/hack_rom_loader.sv | 125 ++++++++++++
 tb/tb_hack_rom_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - streams a counted, checksummed Hack program from a byte host into instruction ROM
module hack_rom_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, DONE, ERR
    } state_t;

    state_t            state, state_nx;
    logic [14:0]       remaining;
    logic [7:0]        hi_byte;
    logic [15:0]       acc;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              load_start;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        cpu_reset  = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        load_start = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                done       = (state == DONE);
                error      = (state == ERR);
                cpu_reset  = (state == ERR);
                load_start = load_req;
                if (load_req) state_nx = CNT_HI;
            end
            CNT_HI: begin
                in_ready  = 1'b1;
                cpu_reset = 1'b1;
                // Counts above 32767 cannot fit the 15-bit word counter.
                if (accept) state_nx = in_data[7] ? ERR : CNT_LO;
            end
            CNT_LO: begin
                in_ready  = 1'b1;
                cpu_reset = 1'b1;
                if (accept) state_nx = ({remaining[14:8], in_data} == 15'd0) ? SUM_HI : DATA_HI;
            end
            DATA_HI: begin
                in_ready  = 1'b1;
                cpu_reset = 1'b1;
                if (accept) state_nx = DATA_LO;
            end
            DATA_LO: begin
                in_ready  = 1'b1;
                cpu_reset = 1'b1;
                if (accept) state_nx = (remaining == 15'd1) ? SUM_HI : DATA_HI;
            end
            SUM_HI: begin
                in_ready  = 1'b1;
                cpu_reset = 1'b1;
                if (accept) state_nx = SUM_LO;
            end
            SUM_LO: begin
                in_ready  = 1'b1;
                cpu_reset = 1'b1;
                if (accept) state_nx = ({hi_byte, in_data} == acc) ? DONE : ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            hi_byte   <= '0;
            acc       <= '0;
            addr      <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
        end else begin
            rom_we <= 1'b0;
            if (load_start) begin
                acc  <= '0;
                addr <= '0;
            end
            if (accept) begin
                case (state)
                    CNT_HI:          remaining[14:8] <= in_data[6:0];
                    CNT_LO:          remaining[7:0]  <= in_data;
                    DATA_HI, SUM_HI: hi_byte         <= in_data;
                    DATA_LO: begin
                        rom_we    <= 1'b1;
                        rom_wdata <= {hi_byte, in_data};
                        rom_addr  <= addr;
                        addr      <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        acc       <= acc + {hi_byte, in_data};
                        remaining <= remaining - 15'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb/tb_hack_rom_loader.sv - scoreboard bench for hack_rom_loader
module tb_hack_rom_loader;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    hack_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_wr = 0;
    bit have_prev = 0;
    bit spacing_on = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  sbuf[$];

    logic [7:0] prog[20] = '{8'h00, 8'h08, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03, 8'hE0, 8'h90,
                             8'h00, 8'h00, 8'hE3, 8'h08, 8'h00, 8'h06, 8'hE0, 8'h07, 8'h8F, 8'hBA};
    logic [15:0] words[8] = '{16'h0002, 16'hEC10, 16'h0003, 16'hE090,
                              16'h0000, 16'hE308, 16'h0006, 16'hE007};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (rom_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rom_we", {17'b0, rom_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rom_addr", {17'b0, rom_addr}, {17'b0, e[30:16]});
                chk("rom_wdata", {16'b0, rom_wdata}, {16'b0, e[15:0]});
            end
            if (spacing_on && have_prev) chk("write_spacing", cyc - prev_wr, 2);
            prev_wr   = cyc;
            have_prev = 1;
        end
    end

    task automatic push_prog(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, i[14:0], words[i]});
    endtask

    task automatic check_flags(input string tag, input logic d, input logic e, input logic c, input logic r);
        chk({tag, "_done"}, {31'b0, done}, {31'b0, d});
        chk({tag, "_error"}, {31'b0, error}, {31'b0, e});
        chk({tag, "_cpu_reset"}, {31'b0, cpu_reset}, {31'b0, c});
        chk({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, r});
    endtask

    task automatic do_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        have_prev = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit jitter, input bit pulse);
        int t;
        if (jitter) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        load_req = pulse;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic send_stream(input int first, input int n, input bit jitter, input bit pulse);
        for (int i = first; i < first + n; i++)
            send_byte(sbuf[i], jitter, pulse && (i == 6 || i == 11));
    endtask

    initial begin
        reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_flags("reset", 0, 0, 0, 0);
        chk("reset_rom_we", {31'b0, rom_we}, 0);
        chk("reset_rom_addr", {17'b0, rom_addr}, 0);
        chk("reset_rom_wdata", {16'b0, rom_wdata}, 0);
        reset = 1'b0;
        @(negedge clk);
        // in_valid while idle must not be consumed
        in_valid = 1'b1; in_data = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        check_flags("idle", 0, 0, 0, 0);

        // Add program, back-to-back bytes
        sbuf.delete();
        foreach (prog[i]) sbuf.push_back(prog[i]);
        do_load();
        check_flags("loading", 0, 0, 1, 1);
        spacing_on = 1;
        push_prog(8);
        send_stream(0, 20, 0, 0);
        spacing_on = 0;
        check_flags("add_ok", 1, 0, 0, 0);
        chk("add_all_written", exp_q.size(), 0);

        // Bad checksum
        sbuf[19] = 8'hBB;
        do_load();
        check_flags("relaunch", 0, 0, 1, 1);
        push_prog(8);
        send_stream(0, 20, 0, 0);
        check_flags("bad_sum", 0, 1, 1, 0);
        chk("bad_all_written", exp_q.size(), 0);

        // Oversized count
        do_load();
        send_byte(8'h80, 0, 0);
        check_flags("cnt_80", 0, 1, 1, 0);

        // Empty program, good and bad checksum
        sbuf.delete();
        sbuf.push_back(8'h00); sbuf.push_back(8'h00); sbuf.push_back(8'h00); sbuf.push_back(8'h00);
        do_load();
        send_stream(0, 4, 0, 0);
        check_flags("empty_ok", 1, 0, 0, 0);
        sbuf[3] = 8'h01;
        do_load();
        send_stream(0, 4, 0, 0);
        check_flags("empty_bad", 0, 1, 1, 0);

        // Jittered valid with load_req pulses mid-stream
        sbuf.delete();
        foreach (prog[i]) sbuf.push_back(prog[i]);
        do_load();
        push_prog(8);
        send_stream(0, 20, 1, 1);
        check_flags("jitter_ok", 1, 0, 0, 0);
        chk("jitter_all_written", exp_q.size(), 0);

        // Reset after the third word is written
        do_load();
        push_prog(3);
        send_stream(0, 8, 0, 0);
        chk("third_write_seen", {31'b0, rom_we}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_flags("mid_reset", 0, 0, 0, 0);
        chk("mid_reset_rom_we", {31'b0, rom_we}, 0);
        chk("mid_reset_rom_addr", {17'b0, rom_addr}, 0);
        chk("mid_reset_rom_wdata", {16'b0, rom_wdata}, 0);
        for (int i = 8; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = sbuf[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_flags("after_abort", 0, 0, 0, 0);
        chk("abort_writes_drained", exp_q.size(), 0);

        do_load();
        push_prog(8);
        send_stream(0, 20, 0, 0);
        check_flags("reload_ok", 1, 0, 0, 0);
        chk("reload_all_written", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
